// File: rtl/adbg_tap_pkg.sv
// Shared TAP definitions: the 1149.1 state encoding, the instruction opcodes,
// and the state transition function used by the TAP controller.
package adbg_tap_pkg;

    typedef enum logic [3:0] {
        TAP_TLR,
        TAP_RTI,
        TAP_SEL_DR,
        TAP_CAP_DR,
        TAP_SH_DR,
        TAP_EX1_DR,
        TAP_PAU_DR,
        TAP_EX2_DR,
        TAP_UPD_DR,
        TAP_SEL_IR,
        TAP_CAP_IR,
        TAP_SH_IR,
        TAP_EX1_IR,
        TAP_PAU_IR,
        TAP_EX2_IR,
        TAP_UPD_IR
    } tap_state_t;

    localparam logic [3:0] IDCODE_INSTR = 4'h2;
    localparam logic [3:0] DEBUG_INSTR  = 4'h8;
    localparam logic [3:0] BYPASS_INSTR = 4'hF;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        n = TAP_TLR;
        case (s)
            TAP_TLR:    n = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    n = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: n = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: n = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  n = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: n = tms ? TAP_UPD_DR : TAP_PAU_DR;
            TAP_PAU_DR: n = tms ? TAP_EX2_DR : TAP_PAU_DR;
            TAP_EX2_DR: n = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: n = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: n = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: n = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  n = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: n = tms ? TAP_UPD_IR : TAP_PAU_IR;
            TAP_PAU_IR: n = tms ? TAP_EX2_IR : TAP_PAU_IR;
            TAP_EX2_IR: n = tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: n = tms ? TAP_SEL_DR : TAP_RTI;
            default:    n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/adbg_jtag_tap.sv
// JTAG TAP controller with IDCODE, DEBUG and BYPASS instructions.
// State decodes are combinational; tdo/tdo_oe are retimed to the tck falling edge.
module adbg_jtag_tap
    import adbg_tap_pkg::*;
#(
    parameter int unsigned       IR_LEN       = 4,
    parameter logic [31:0]       IDCODE_VALUE = 32'h149511C3,
    parameter logic [IR_LEN-1:0] IDCODE_INSTR = IR_LEN'(adbg_tap_pkg::IDCODE_INSTR),
    parameter logic [IR_LEN-1:0] DEBUG_INSTR  = IR_LEN'(adbg_tap_pkg::DEBUG_INSTR),
    parameter logic [IR_LEN-1:0] BYPASS_INSTR = IR_LEN'(adbg_tap_pkg::BYPASS_INSTR)
) (
    input  logic tck_i,
    input  logic trstn_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic capture_dr_o,
    output logic test_logic_reset_o,
    output logic debug_select_o,
    input  logic debug_tdo_i
);

    tap_state_t        state;
    tap_state_t        state_nxt;
    logic [IR_LEN-1:0] ir_shift;
    logic [IR_LEN-1:0] ir_latch;
    logic [31:0]       idcode;
    logic              bypass;
    logic              sel_idcode;
    logic              sel_debug;
    logic              sel_bypass;
    logic              tdo_src;

    always_comb state_nxt = tap_next(state, tms_i);

    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            state <= TAP_TLR;
        end else begin
            state <= state_nxt;
        end
    end

    assign test_logic_reset_o = (state == TAP_TLR);
    assign shift_dr_o         = (state == TAP_SH_DR);
    assign pause_dr_o         = (state == TAP_PAU_DR);
    assign update_dr_o        = (state == TAP_UPD_DR);
    assign capture_dr_o       = (state == TAP_CAP_DR);

    assign sel_idcode     = (ir_latch == IDCODE_INSTR);
    assign sel_debug      = (ir_latch == DEBUG_INSTR);
    // Unknown opcodes fall back to bypass alongside the explicit BYPASS opcode.
    assign sel_bypass     = (ir_latch == BYPASS_INSTR) || !(sel_idcode || sel_debug);
    assign debug_select_o = sel_debug;

    // The latch takes IDCODE on the edge entering TLR so it already reads IDCODE there.
    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            ir_shift <= '0;
            ir_latch <= IDCODE_INSTR;
        end else begin
            if (state == TAP_CAP_IR) begin
                ir_shift <= IR_LEN'(2'b01);
            end else if (state == TAP_SH_IR) begin
                ir_shift <= {tdi_i, ir_shift[IR_LEN-1:1]};
            end
            if (state_nxt == TAP_TLR) begin
                ir_latch <= IDCODE_INSTR;
            end else if (state == TAP_UPD_IR) begin
                ir_latch <= ir_shift;
            end
        end
    end

    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            idcode <= '0;
            bypass <= 1'b0;
        end else if (state == TAP_CAP_DR) begin
            if (sel_idcode) begin
                idcode <= IDCODE_VALUE;
            end
            bypass <= 1'b0;
        end else if (state == TAP_SH_DR) begin
            if (sel_idcode) begin
                idcode <= {tdi_i, idcode[31:1]};
            end
            bypass <= tdi_i;
        end
    end

    always_comb begin
        tdo_src = 1'b0;
        if (state == TAP_SH_IR) begin
            tdo_src = ir_shift[0];
        end else if (state == TAP_SH_DR) begin
            if (sel_idcode) begin
                tdo_src = idcode[0];
            end else if (sel_debug) begin
                tdo_src = debug_tdo_i;
            end else if (sel_bypass) begin
                tdo_src = bypass;
            end
        end
    end

    always_ff @(negedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            tdo_o    <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else begin
            tdo_o    <= tdo_src;
            tdo_oe_o <= (state == TAP_SH_IR) || (state == TAP_SH_DR);
        end
    end

endmodule

// File: tb/tb_adbg_jtag_tap.sv
// Directed bench for adbg_jtag_tap: a table-driven TAP model checked every cycle,
// plus literal expectations for the IDCODE, IR capture, bypass, debug and reset scenarios.
module tb_adbg_jtag_tap;

    logic tck = 1'b0;
    logic trstn, tms, tdi, dbg_tdo;
    logic tdo, tdo_oe, shdr, pdr, udr, cdr, tlr, dsel;

    int vectors = 0;
    int miscompares = 0;

    adbg_jtag_tap dut (
        .tck_i(tck), .trstn_i(trstn), .tms_i(tms), .tdi_i(tdi),
        .tdo_o(tdo), .tdo_oe_o(tdo_oe),
        .shift_dr_o(shdr), .pause_dr_o(pdr), .update_dr_o(udr), .capture_dr_o(cdr),
        .test_logic_reset_o(tlr), .debug_select_o(dsel), .debug_tdo_i(dbg_tdo)
    );

    always #10 tck = ~tck;

    localparam int M_TLR = 0, M_RTI = 1, M_SDS = 2, M_CDR = 3, M_SDR = 4, M_E1D = 5,
                   M_PDR = 6, M_E2D = 7, M_UDR = 8, M_SIS = 9, M_CIR = 10, M_SIR = 11,
                   M_E1I = 12, M_PIR = 13, M_E2I = 14, M_UIR = 15;
    // Successor tables indexed by state, for tms=0 and tms=1.
    int nx0 [16] = '{M_RTI, M_RTI, M_CDR, M_SDR, M_SDR, M_PDR, M_PDR, M_SDR,
                     M_RTI, M_CIR, M_SIR, M_SIR, M_PIR, M_PIR, M_SIR, M_RTI};
    int nx1 [16] = '{M_TLR, M_SDS, M_SIS, M_E1D, M_E1D, M_UDR, M_E2D, M_UDR,
                     M_SDS, M_TLR, M_E1I, M_E1I, M_UIR, M_E2I, M_UIR, M_SDS};

    localparam logic [31:0] IDV = 32'h149511C3;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model, advanced and compared once per tck edge pair.
    int          ms = M_TLR;
    logic [3:0]  m_irs = 4'h0, m_irl = 4'h2;
    logic [31:0] m_id = 32'h0;
    logic        m_byp = 1'b0, m_tdo = 1'b0, m_oe = 1'b0;

    initial begin
        forever begin
            @(posedge tck);
            if (!trstn) begin
                ms = M_TLR; m_irs = 4'h0; m_irl = 4'h2; m_id = 32'h0; m_byp = 1'b0;
            end else begin
                if (ms == M_CIR) m_irs = 4'h1;
                if (ms == M_SIR) m_irs = {tdi, m_irs[3:1]};
                if (ms == M_UIR) m_irl = m_irs;
                if (ms == M_CDR) begin
                    if (m_irl == 4'h2) m_id = IDV;
                    m_byp = 1'b0;
                end
                if (ms == M_SDR) begin
                    if (m_irl == 4'h2) m_id = {tdi, m_id[31:1]};
                    m_byp = tdi;
                end
                ms = tms ? nx1[ms] : nx0[ms];
                if (ms == M_TLR) m_irl = 4'h2;
            end
            #5;
            chk("m_tlr", {31'b0, tlr}, {31'b0, ms == M_TLR});
            chk("m_shift_dr", {31'b0, shdr}, {31'b0, ms == M_SDR});
            chk("m_pause_dr", {31'b0, pdr}, {31'b0, ms == M_PDR});
            chk("m_update_dr", {31'b0, udr}, {31'b0, ms == M_UDR});
            chk("m_capture_dr", {31'b0, cdr}, {31'b0, ms == M_CDR});
            chk("m_debug_select", {31'b0, dsel}, {31'b0, m_irl == 4'h8});
            @(negedge tck);
            m_oe  = trstn && (ms == M_SIR || ms == M_SDR);
            m_tdo = 1'b0;
            if (trstn && ms == M_SIR) m_tdo = m_irs[0];
            if (trstn && ms == M_SDR)
                m_tdo = (m_irl == 4'h2) ? m_id[0] : (m_irl == 4'h8) ? dbg_tdo : m_byp;
            #3;
            chk("m_tdo", {31'b0, tdo}, {31'b0, m_tdo});
            chk("m_tdo_oe", {31'b0, tdo_oe}, {31'b0, m_oe});
        end
    end

    // One tck: inputs applied, returns 4 time units after the falling edge.
    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge tck);
        @(negedge tck);
        #4;
    endtask

    // From a shift state: record tdo, then shift n bits, leaving via Exit1.
    task automatic shift(input int n, input logic [31:0] din, output logic [31:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            step(i == n - 1, din[i]);
        end
    endtask

    task automatic to_shdr();  // from RTI
        step(1, 0); step(0, 0); step(0, 0);
    endtask

    task automatic to_shir();  // from RTI
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    endtask

    task automatic exit_rti();  // from Exit1
        step(1, 0); step(0, 0);
    endtask

    task automatic load_ir(input logic [3:0] op);
        logic [31:0] d;
        to_shir();
        shift(4, {28'b0, op}, d);
        chk("ir_capture_bits", d, 32'h1);
        exit_rti();
    endtask

    initial begin
        logic [31:0] d, lo, hi;
        trstn = 1'b0; tms = 1'b1; tdi = 1'b0; dbg_tdo = 1'b0;
        #5;
        chk("rst_tlr", {31'b0, tlr}, 32'h1);
        chk("rst_tdo_oe", {31'b0, tdo_oe}, 32'h0);
        chk("rst_debug_select", {31'b0, dsel}, 32'h0);
        step(0, 0); step(0, 0);
        trstn = 1'b1;
        step(0, 0);

        // IDCODE readout, split across a Pause-DR to check the register holds.
        to_shdr();
        chk("idcode_oe", {31'b0, tdo_oe}, 32'h1);
        shift(16, 32'h0, lo);
        step(0, 0); step(0, 0); step(1, 0); step(0, 0);
        shift(16, 32'h0, hi);
        chk("idcode_stream", {hi[15:0], lo[15:0]}, 32'h149511C3);
        exit_rti();

        // IR capture pattern, then a bypass opcode, then DEBUG.
        to_shir();
        shift(4, 32'hA, d);
        chk("ir_capture_A", d, 32'h1);
        exit_rti();
        chk("dsel_after_A", {31'b0, dsel}, 32'h0);
        load_ir(4'h8);
        chk("dsel_after_8", {31'b0, dsel}, 32'h1);

        // DEBUG: tdo follows debug_tdo at the next falling edge.
        to_shdr();
        chk("debug_tdo_0", {31'b0, tdo}, 32'h0);
        dbg_tdo = 1'b1;
        step(0, 0);
        chk("debug_tdo_1", {31'b0, tdo}, 32'h1);
        dbg_tdo = 1'b0;
        step(0, 0);
        chk("debug_tdo_0b", {31'b0, tdo}, 32'h0);
        step(1, 0); step(0, 0);
        chk("pause_dr", {31'b0, pdr}, 32'h1);
        chk("pause_oe", {31'b0, tdo_oe}, 32'h0);

        // Five tms=1 edges from Shift-DR reach TLR and restore IDCODE.
        step(1, 0); step(0, 0);
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("tlr_after_5", {31'b0, tlr}, 32'h1);
        chk("tlr_dsel", {31'b0, dsel}, 32'h0);
        step(0, 0);
        to_shdr();
        shift(32, 32'h0, d);
        chk("idcode_after_tlr", d, 32'h149511C3);
        exit_rti();

        // BYPASS: pattern 1,0,1,1 returns one tck late behind the captured 0.
        load_ir(4'hF);
        to_shdr();
        shift(5, 32'b01101, d);
        chk("bypass_stream", d, 32'b11010);
        exit_rti();

        // Reset in the middle of an IR shift.
        load_ir(4'h8);
        chk("dsel_before_rst", {31'b0, dsel}, 32'h1);
        to_shir();
        step(0, 1); step(0, 0);
        trstn = 1'b0;
        #1;
        chk("midrst_tlr", {31'b0, tlr}, 32'h1);
        chk("midrst_dsel", {31'b0, dsel}, 32'h0);
        chk("midrst_tdo", {31'b0, tdo}, 32'h0);
        chk("midrst_oe", {31'b0, tdo_oe}, 32'h0);
        chk("midrst_shdr", {31'b0, shdr}, 32'h0);
        step(1, 0);
        trstn = 1'b1;
        step(0, 0);
        chk("post_rst_dsel", {31'b0, dsel}, 32'h0);
        to_shdr();
        shift(32, 32'h0, d);
        chk("idcode_after_rst", d, 32'h149511C3);
        exit_rti();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adbg_jtag_tap.md
ADBG_JTAG_TAP -- requirements
Module: adbg_jtag_tap

Interface
REQ-001 SHALL have parameter IR_LEN, default 4, instruction register width.
REQ-002 SHALL have parameter IDCODE_VALUE, default 32'h149511C3, value captured into the IDCODE register; bit 0 SHALL be 1.
REQ-003 SHALL have parameters IDCODE_INSTR = 4'h2, DEBUG_INSTR = 4'h8 and BYPASS_INSTR = 4'hF, the instruction opcodes.
REQ-004 SHALL have port tck_i, input, 1, JTAG clock.
REQ-005 SHALL have port trstn_i, input, 1, JTAG reset, asynchronous, active-low.
REQ-006 SHALL have port tms_i, input, 1, test mode select, sampled on tck_i rising edge.
REQ-007 SHALL have port tdi_i, input, 1, serial data in, forwarded unregistered to downstream debug logic.
REQ-008 SHALL have port tdo_o, output, 1, serial data out.
REQ-009 SHALL have port tdo_oe_o, output, 1, tdo_o drive enable.
REQ-010 SHALL have ports shift_dr_o, pause_dr_o, update_dr_o and capture_dr_o, each output, 1, high while the TAP is in the matching state.
REQ-011 SHALL have port test_logic_reset_o, output, 1, high in Test-Logic-Reset.
REQ-012 SHALL have port debug_select_o, output, 1, high while the latched IR equals DEBUG_INSTR.
REQ-013 SHALL have port debug_tdo_i, input, 1, serial return from the debug module top.

Function
REQ-014 SHALL implement the 16-state IEEE 1149.1 TAP FSM, advancing on tck_i rising edge per tms_i.
- Transitions are TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR and the IR equivalents.
- Standard 1149.1 arcs only.
REQ-015 SHALL move to Test-Logic-Reset from any state after 5 consecutive tck_i rising edges with tms_i=1.
REQ-016 State outputs (REQ-010/011) SHALL be combinational decodes of the current state register, with no added latency.
REQ-017 In Capture-IR the IR shift register SHALL load {(IR_LEN-2)'b0, 2'b01}.
REQ-018 In Shift-IR the IR shift register SHALL shift right with tdi_i entering the MSB.
REQ-019 The latched IR SHALL load the IR shift register on the tck_i rising edge while in Update-IR.
REQ-020 The latched IR SHALL become IDCODE_INSTR in Test-Logic-Reset.
REQ-021 In Capture-DR with IDCODE selected, the 32-bit IDCODE register SHALL load IDCODE_VALUE.
REQ-022 In Shift-DR with IDCODE selected, the IDCODE register SHALL shift right with tdi_i into bit 31.
REQ-023 The 1-bit bypass register SHALL load 0 in Capture-DR and load tdi_i in Shift-DR.
REQ-024 Any IR value other than IDCODE_INSTR or DEBUG_INSTR SHALL select bypass.
REQ-025 The TDO source SHALL be ir_shift[0] in Shift-IR; in Shift-DR it SHALL be idcode[0] for IDCODE, debug_tdo_i for DEBUG, or bypass otherwise.
REQ-026 tdo_o and tdo_oe_o SHALL be registered on tck_i falling edge.
REQ-027 tdo_oe_o SHALL be 1 only when the state was Shift-IR or Shift-DR, giving half-cycle latency.
REQ-028 In non-shift states tdo_o SHALL be 0.
REQ-029 The IDCODE and bypass registers SHALL hold their value in Pause-DR and the Exit states.
REQ-030 An IR update SHALL NOT alter the IDCODE or bypass contents.

Reset
REQ-031 trstn_i=0 SHALL asynchronously force the following:
- state = Test-Logic-Reset
- latched IR = IDCODE_INSTR
- IR shift = 0, IDCODE register = 0, bypass = 0
- tdo_o = 0, tdo_oe_o = 0
REQ-032 Consequently the outputs during reset SHALL be test_logic_reset_o=1, debug_select_o=0, and shift/pause/update/capture_dr_o=0.
REQ-033 Deassertion of trstn_i mid-shift SHALL resume from Test-Logic-Reset, with no partial IR update.

Structure
REQ-034 A shared package adbg_tap_pkg SHALL hold the following:
- the tap_state_t enum (16 states)
- the IR opcode constants IDCODE_INSTR, DEBUG_INSTR and BYPASS_INSTR
REQ-035 The design SHALL be a single module with no sub-modules.
- The FSM, IR, the DR registers and the TDO mux are separate always blocks.

Verification
REQ-036 Apply trstn_i low, then tms 0 to RTI, then shift 32 DR bits -> tdo_o stream equals 32'h149511C3, LSB first; tdo_oe_o high during the shift.
REQ-037 Shift IR with tdi pattern 4'hA -> captured bits out are 1,0,0,0; after Update-IR with 4'h8, debug_select_o=1.
REQ-038 With BYPASS loaded, shift DR pattern 1011 -> tdo_o reproduces the pattern delayed by one tck.
REQ-039 From ShDR, drive tms_i=1 for 5 cycles -> test_logic_reset_o=1, IR reads IDCODE_INSTR, debug_select_o=0.
REQ-040 With DEBUG selected in ShDR, toggle debug_tdo_i -> tdo_o follows on the next falling edge; then enter PauDR -> pause_dr_o=1, tdo_oe_o=0.
REQ-041 Assert trstn_i low in the middle of Shift-IR -> immediate TLR, with all outputs at reset values within the same cycle.
